// File: rtl/ram512_block_mover.sv
// ram512_block_mover: sequential fill / copy engine in front of a 512-word RAM.
// Fill writes one constant per cycle over an address range. Copy moves a range
// two cycles per word: one cycle to read the source, one cycle to write it.
// Address arithmetic is modulo 2**ADDR_W, so a range that runs past the top of
// the RAM wraps round to address 0.
module ram512_block_mover #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  // Largest request the RAM can hold; longer requests are clamped to it.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t state;
  state_t state_nxt;

  // Operands captured when a request is accepted, so the caller may change
  // its inputs freely while the operation runs.
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] fill_q;
  logic [LEN_W-1:0]  last_q;    // index of the final word (clamped len - 1)
  logic [LEN_W-1:0]  idx_q;     // word index i within the range
  logic [DATA_W-1:0] hold_q;    // source word read in RD, written in WR

  logic [LEN_W-1:0]  len_clamped;
  logic [ADDR_W-1:0] offset;
  logic              is_last;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  // idx_q never exceeds 511 while addressing, so the low bits are the offset.
  assign offset      = idx_q[ADDR_W-1:0];
  assign is_last     = (idx_q == last_q);

  // State register; reset drops the engine straight back to IDLE.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode, purely from registered state and counters.
  // NOTE: every output gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            state_nxt = S_DONE;
          end else if (mode) begin
            state_nxt = S_RD;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end

      S_FILL: begin
        mem_address = dst_q + offset;
        mem_in      = fill_q;
        mem_load    = 1'b1;
        busy        = 1'b1;
        if (is_last) begin
          state_nxt = S_DONE;
        end
      end

      S_RD: begin
        mem_address = src_q + offset;
        busy        = 1'b1;
        state_nxt   = S_WR;
      end

      S_WR: begin
        mem_address = dst_q + offset;
        mem_in      = hold_q;
        mem_load    = 1'b1;
        busy        = 1'b1;
        state_nxt   = is_last ? S_DONE : S_RD;
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, word counter and copy hold register.
  // NOTE: the hold register is an ordinary flop, not a memory, so it is
  // cleared by reset along with every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      fill_q <= '0;
      last_q <= '0;
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q  <= src;
            dst_q  <= dst;
            fill_q <= fill_val;
            // Wraps to all-ones for len=0, which is harmless: that request
            // goes straight to DONE and never consults last_q.
            last_q <= len_clamped - LEN_W'(1);
            idx_q  <= '0;
          end
        end
        S_FILL:  idx_q  <= idx_q + LEN_W'(1);
        S_RD:    hold_q <= mem_out;
        S_WR:    idx_q  <= idx_q + LEN_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_block_mover.sv
// Testbench for ram512_block_mover: a behavioural RAM512 sits behind the DUT,
// a reference memory image predicts every write, and the expected writes are
// queued when a request is issued and popped as the DUT performs them.
module tb_ram512_block_mover;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] mem_in;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_load;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  ram512_block_mover #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill_val   (fill_val),
    .mem_out    (mem_out),
    .mem_in     (mem_in),
    .mem_address(mem_address),
    .mem_load   (mem_load),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural RAM512: combinational read, write on the edge while load=1.
  // A side port lets the bench preload words while the DUT is idle.
  logic [DATA_W-1:0] ram [512] = '{default: '0};
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (mem_load) ram[mem_address] <= mem_in;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end
  assign mem_out = ram[mem_address];

  // Reference image of what the RAM should hold.
  logic [DATA_W-1:0] model [512];

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ram(input string tag, input int addr);
    check($sformatf("%s ram[%0d]", tag, addr), 32'(ram[addr]), 32'(model[addr]));
  endtask

  task automatic preload(input int addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = ADDR_W'(addr);
    pre_data = data;
    model[addr] = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Queue the predicted writes (at most max_words of them), then present the
  // request for one edge and scramble the inputs straight afterwards.
  task automatic issue(input logic m, input int s, input int d, input int l,
                       input logic [DATA_W-1:0] fv, input int max_words);
    int n;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] sa;
    wr_t w;
    n = (l > 512) ? 512 : l;
    for (int j = 0; j < n && j < max_words; j++) begin
      a  = ADDR_W'(d + j);
      sa = ADDR_W'(s + j);
      w.addr = a;
      if (m == 1'b0) begin
        w.data = fv;
        w.cyc  = j + 1;
      end else begin
        w.data = model[sa];
        w.cyc  = 2 * (j + 1);
      end
      model[a] = w.data;
      exp_q.push_back(w);
    end
    @(negedge clk);
    start    = 1'b1;
    mode     = m;
    src      = ADDR_W'(s);
    dst      = ADDR_W'(d);
    len      = LEN_W'(l);
    fill_val = fv;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mode     = ~m;
    src      = ~ADDR_W'(s);
    dst      = ~ADDR_W'(d);
    len      = LEN_W'(5);
    fill_val = ~fv;
  endtask

  // Watch ncyc cycles after acceptance, comparing each write against the
  // scoreboard. pulse_cyc re-asserts start for one cycle; abort_cyc applies
  // an asynchronous reset between edges in that cycle.
  task automatic monitor(input string tag, input int ncyc, input int exp_done_at,
                         input int exp_busy, input int pulse_cyc, input int abort_cyc);
    int done_cnt = 0;
    int done_at  = -1;
    int busy_cnt = 0;
    int extra    = 0;
    wr_t w;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_cyc);
      if (cyc == abort_cyc) begin
        check({tag, " load before reset"}, 32'(mem_load), 32'd1);
        #2 reset = 1'b1;
        #1;
        check({tag, " load after reset"}, 32'(mem_load), 32'd0);
        check({tag, " busy after reset"}, 32'(busy), 32'd0);
        check({tag, " addr after reset"}, 32'(mem_address), 32'd0);
        check({tag, " in after reset"}, 32'(mem_in), 32'd0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          if (done) done_cnt++;
          if (busy) busy_cnt++;
        end
        reset = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (mem_load) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          w = exp_q.pop_front();
          check($sformatf("%s wr%0d addr", tag, cyc), 32'(mem_address), 32'(w.addr));
          check($sformatf("%s wr%0d data", tag, cyc), 32'(mem_in), 32'(w.data));
          check($sformatf("%s wr%0d cycle", tag, cyc), cyc, w.cyc);
        end
      end
    end
    start = 1'b0;
    check({tag, " done count"}, done_cnt, (exp_done_at < 0) ? 0 : 1);
    check({tag, " done cycle"}, done_at, exp_done_at);
    check({tag, " busy cycles"}, busy_cnt, exp_busy);
    check({tag, " extra writes"}, extra, 0);
    check({tag, " writes left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    for (int k = 0; k < 512; k++) model[k] = '0;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    fill_val = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst mem_load", 32'(mem_load), 32'd0);
    check("rst mem_address", 32'(mem_address), 32'd0);
    check("rst mem_in", 32'(mem_in), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    reset = 1'b0;

    // Fill dst=10 len=4.
    issue(1'b0, 0, 10, 4, 16'hABCD, 1024);
    monitor("fill", 7, 5, 4, 0, 0);
    for (int a = 9; a <= 14; a++) check_ram("fill", a);

    // Copy 100..102 -> 200..202.
    preload(100, 16'd1);
    preload(101, 16'd2);
    preload(102, 16'd3);
    issue(1'b1, 100, 200, 3, 16'h0000, 1024);
    monitor("copy", 9, 7, 6, 0, 0);
    for (int a = 200; a <= 202; a++) check_ram("copy", a);
    for (int a = 100; a <= 102; a++) check_ram("copy src", a);
    check_ram("copy", 203);

    // Overlapping copy src=0 dst=1 with a stray start mid-operation.
    preload(0, 16'd5);
    preload(1, 16'd6);
    preload(2, 16'd7);
    preload(3, 16'd8);
    issue(1'b1, 0, 1, 3, 16'h0000, 1024);
    monitor("overlap", 10, 7, 6, 3, 0);
    for (int a = 0; a <= 4; a++) check_ram("overlap", a);

    // Zero-length request.
    issue(1'b0, 0, 50, 0, 16'hFFFF, 1024);
    monitor("len0", 3, 1, 0, 0, 0);
    check_ram("len0", 50);

    // Wrap past address 511.
    issue(1'b0, 0, 510, 3, 16'd7, 1024);
    monitor("wrap", 6, 4, 3, 0, 0);
    check_ram("wrap", 510);
    check_ram("wrap", 511);
    check_ram("wrap", 0);
    check_ram("wrap", 1);

    // Oversized request clamped to 512 words.
    issue(1'b0, 0, 0, 600, 16'h5A5A, 1024);
    monitor("clamp", 515, 513, 512, 0, 0);
    check_ram("clamp", 0);
    check_ram("clamp", 511);

    // Copy of 8 words aborted by reset during the third write cycle.
    for (int k = 0; k < 8; k++) preload(20 + k, DATA_W'(16'h0100 + k));
    issue(1'b1, 20, 40, 8, 16'h0000, 2);
    monitor("abort", 20, -1, 5, 0, 6);
    for (int a = 40; a <= 43; a++) check_ram("abort", a);

    // Fill after reset release.
    issue(1'b0, 0, 300, 2, 16'h1234, 1024);
    monitor("post", 5, 3, 2, 0, 0);
    for (int a = 299; a <= 302; a++) check_ram("post", a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
